// File: rtl/demux_sel_ctrl.sv
// Select sequencer driving the a/en inputs of a 5-to-32 decoder.
// Single-select requests or a full 0..31 scan, each with a dwell and a break-before-make gap.
module demux_sel_ctrl #(
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_addr,
    input  logic [CNT_W-1:0] req_len,
    input  logic             scan_start,
    input  logic [CNT_W-1:0] scan_dwell,
    output logic [4:0]       a,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic             scan_done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [4:0]       LAST     = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] dwell_cnt_nxt;
    logic [CNT_W-1:0] scan_len;
    logic [CNT_W-1:0] scan_len_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_nxt;
    logic             scan_mode;
    logic             scan_mode_nxt;
    logic [4:0]       a_nxt;
    logic             en_nxt;
    logic             done_nxt;
    logic             scan_done_nxt;
    logic             accept;
    logic [CNT_W-1:0] req_len_eff;
    logic [CNT_W-1:0] scan_dwell_eff;
    logic [CNT_W-1:0] dwell_dec;

    assign req_ready      = (state == IDLE) && !rst;
    assign accept         = req_valid && req_ready;
    assign busy           = (state != IDLE);
    assign req_len_eff    = (req_len == '0) ? ONE : req_len;
    assign scan_dwell_eff = (scan_dwell == '0) ? ONE : scan_dwell;
    assign dwell_dec      = dwell_cnt - ONE;

    // dwell_cnt holds the dwell cycles remaining including the current one;
    // done is registered, so it is raised on the edge entering the last cycle.
    always_comb begin
        state_nxt     = state;
        a_nxt         = a;
        en_nxt        = en;
        done_nxt      = 1'b0;
        scan_done_nxt = 1'b0;
        dwell_cnt_nxt = dwell_cnt;
        scan_len_nxt  = scan_len;
        gap_cnt_nxt   = gap_cnt;
        scan_mode_nxt = scan_mode;

        case (state)
            IDLE: begin
                en_nxt = 1'b0;
                if (accept) begin
                    state_nxt     = ACTIVE;
                    a_nxt         = req_addr;
                    en_nxt        = 1'b1;
                    dwell_cnt_nxt = req_len_eff;
                    done_nxt      = (req_len_eff == ONE);
                    scan_mode_nxt = 1'b0;
                end else if (scan_start) begin
                    state_nxt     = ACTIVE;
                    a_nxt         = 5'd0;
                    en_nxt        = 1'b1;
                    dwell_cnt_nxt = scan_dwell_eff;
                    scan_len_nxt  = scan_dwell_eff;
                    done_nxt      = (scan_dwell_eff == ONE);
                    scan_mode_nxt = 1'b1;
                end
            end

            ACTIVE: begin
                if (dwell_cnt > ONE) begin
                    dwell_cnt_nxt = dwell_dec;
                    done_nxt      = (dwell_dec == ONE);
                    scan_done_nxt = scan_mode && (dwell_dec == ONE) && (a == LAST);
                end else if (GAP_CYCLES > 0) begin
                    state_nxt   = GAP;
                    en_nxt      = 1'b0;
                    gap_cnt_nxt = GAP_LOAD;
                end else if (scan_mode && (a != LAST)) begin
                    // No gap: step straight to the next line on the same edge.
                    state_nxt     = ACTIVE;
                    a_nxt         = a + 5'd1;
                    en_nxt        = 1'b1;
                    dwell_cnt_nxt = scan_len;
                    done_nxt      = (scan_len == ONE);
                    scan_done_nxt = (scan_len == ONE) && (a == 5'd30);
                end else begin
                    state_nxt = IDLE;
                    en_nxt    = 1'b0;
                end
            end

            GAP: begin
                en_nxt = 1'b0;
                if (gap_cnt > GAP_ONE) begin
                    gap_cnt_nxt = gap_cnt - GAP_ONE;
                end else if (scan_mode && (a != LAST)) begin
                    state_nxt     = ACTIVE;
                    a_nxt         = a + 5'd1;
                    en_nxt        = 1'b1;
                    dwell_cnt_nxt = scan_len;
                    done_nxt      = (scan_len == ONE);
                    scan_done_nxt = (scan_len == ONE) && (a == 5'd30);
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a         <= 5'd0;
            en        <= 1'b0;
            done      <= 1'b0;
            scan_done <= 1'b0;
            dwell_cnt <= '0;
            scan_len  <= '0;
            gap_cnt   <= '0;
            scan_mode <= 1'b0;
        end else begin
            state     <= state_nxt;
            a         <= a_nxt;
            en        <= en_nxt;
            done      <= done_nxt;
            scan_done <= scan_done_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            scan_len  <= scan_len_nxt;
            gap_cnt   <= gap_cnt_nxt;
            scan_mode <= scan_mode_nxt;
        end
    end

endmodule

// File: tb/tb_demux_sel_ctrl.sv
// Directed bench for demux_sel_ctrl: one instance with a 1-cycle gap, one with no gap.
module tb_demux_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, scan_start;
    logic [4:0] req_addr, a;
    logic [7:0] req_len, scan_dwell;
    logic       en, busy, done, scan_done;

    logic       z_req_valid, z_req_ready, z_scan_start;
    logic [4:0] z_req_addr, z_a;
    logic [7:0] z_req_len, z_scan_dwell;
    logic       z_en, z_busy, z_done, z_scan_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_sel_ctrl #(.GAP_CYCLES(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .scan_start(scan_start), .scan_dwell(scan_dwell),
        .a(a), .en(en), .busy(busy), .done(done), .scan_done(scan_done)
    );

    demux_sel_ctrl #(.GAP_CYCLES(0), .CNT_W(8)) dut_nogap (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_addr(z_req_addr), .req_len(z_req_len),
        .scan_start(z_scan_start), .scan_dwell(z_scan_dwell),
        .a(z_a), .en(z_en), .busy(z_busy), .done(z_done), .scan_done(z_scan_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Active-low one-hot decoder output as the downstream decoder5x32 would drive it.
    function automatic logic [31:0] decode(input logic e, input logic [4:0] addr);
        return e ? ~(32'h1 << addr) : 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] addr, input logic [7:0] len,
                                 input logic s, input logic [7:0] d);
        req_valid  = v;
        req_addr   = addr;
        req_len    = len;
        scan_start = s;
        scan_dwell = d;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, ph, scan_pulses;
        logic prev_en;
        logic [4:0] prev_a;

        rst = 1'b1;
        applyStimulus(1'b1, 5'd3, 8'd2, 1'b0, 8'd0);
        z_req_valid = 1'b0; z_req_addr = 5'd0; z_req_len = 8'd0;
        z_scan_start = 1'b0; z_scan_dwell = 8'd0;
        tick();
        tick();
        $display("[TB] reset with req_valid high");
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_en", en, 0);
        checkOutput("rst_a", a, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_y", decode(en, a), 32'hFFFF_FFFF);
        checkOutput("rst_z_ready", z_req_ready, 0);

        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 8'd0);
        tick();
        checkOutput("idle_ready", req_ready, 1);
        checkOutput("idle_busy", busy, 0);

        $display("[TB] request addr 5 len 3");
        applyStimulus(1'b1, 5'd5, 8'd3, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 5'd9, 8'd7, 1'b0, 8'd0);
        for (int i = 1; i <= 3; i++) begin
            checkOutput($sformatf("r5_en_c%0d", i), en, 1);
            checkOutput($sformatf("r5_a_c%0d", i), a, 5);
            checkOutput($sformatf("r5_y_c%0d", i), decode(en, a), 32'hFFFF_FFDF);
            checkOutput($sformatf("r5_done_c%0d", i), done, (i == 3));
            checkOutput($sformatf("r5_ready_c%0d", i), req_ready, 0);
            checkOutput($sformatf("r5_busy_c%0d", i), busy, 1);
            tick();
        end
        checkOutput("r5_gap_en", en, 0);
        checkOutput("r5_gap_a", a, 5);
        checkOutput("r5_gap_y", decode(en, a), 32'hFFFF_FFFF);
        checkOutput("r5_gap_done", done, 0);
        checkOutput("r5_gap_ready", req_ready, 0);
        tick();
        checkOutput("r5_ready_back", req_ready, 1);
        checkOutput("r5_busy_fall", busy, 0);

        $display("[TB] request addr 31 len 0");
        applyStimulus(1'b1, 5'd31, 8'd0, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 8'd0);
        checkOutput("r31_en", en, 1);
        checkOutput("r31_y", decode(en, a), 32'h7FFF_FFFF);
        checkOutput("r31_done", done, 1);
        tick();
        checkOutput("r31_gap_en", en, 0);
        checkOutput("r31_gap_done", done, 0);
        tick();
        checkOutput("r31_ready", req_ready, 1);

        $display("[TB] request and scan_start together");
        applyStimulus(1'b1, 5'd2, 8'd1, 1'b1, 8'd4);
        tick();
        applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 8'd0);
        checkOutput("both_en", en, 1);
        checkOutput("both_a", a, 2);
        checkOutput("both_done", done, 1);
        tick();
        checkOutput("both_gap_en", en, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("both_noscan_busy%0d", i), busy, 0);
            checkOutput($sformatf("both_noscan_en%0d", i), en, 0);
            tick();
        end

        $display("[TB] scan dwell 2");
        applyStimulus(1'b0, 5'd0, 8'd0, 1'b1, 8'd2);
        tick();
        scan_start = 1'b0;
        scan_dwell = 8'd9;
        scan_pulses = 0;
        prev_en = 1'b0;
        prev_a = 5'd0;
        for (int c = 1; c <= 96; c++) begin
            n  = (c - 1) / 3;
            ph = (c - 1) % 3;
            checkOutput($sformatf("scan_en_c%0d", c), en, (ph < 2));
            checkOutput($sformatf("scan_a_c%0d", c), a, n);
            checkOutput($sformatf("scan_done_c%0d", c), done, (ph == 1));
            checkOutput($sformatf("scan_sdone_c%0d", c), scan_done, (ph == 1 && n == 31));
            checkOutput($sformatf("scan_busy_c%0d", c), busy, 1);
            checkOutput($sformatf("scan_break_c%0d", c), (prev_en && en && (a != prev_a)), 0);
            if (scan_done) scan_pulses++;
            prev_en = en;
            prev_a = a;
            scan_start = (c == 10);
            tick();
            scan_start = 1'b0;
        end
        checkOutput("scan_end_busy", busy, 0);
        checkOutput("scan_end_ready", req_ready, 1);
        checkOutput("scan_end_en", en, 0);
        checkOutput("scan_end_a", a, 31);
        checkOutput("scan_pulse_count", scan_pulses, 1);

        $display("[TB] reset during scan");
        applyStimulus(1'b0, 5'd0, 8'd0, 1'b1, 8'd2);
        tick();
        scan_start = 1'b0;
        for (int c = 1; c < 31; c++) tick();
        checkOutput("mid_a10", a, 10);
        checkOutput("mid_en", en, 1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_en", en, 0);
        checkOutput("mid_rst_a", a, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_ready", req_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rel_ready", req_ready, 1);
        applyStimulus(1'b1, 5'd1, 8'd2, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 8'd0);
        checkOutput("r1_en_c1", en, 1);
        checkOutput("r1_a_c1", a, 1);
        checkOutput("r1_done_c1", done, 0);
        tick();
        checkOutput("r1_en_c2", en, 1);
        checkOutput("r1_done_c2", done, 1);
        tick();
        checkOutput("r1_gap_en", en, 0);
        checkOutput("r1_gap_a", a, 1);
        tick();
        checkOutput("r1_ready", req_ready, 1);

        $display("[TB] no-gap instance: request addr 7 len 2");
        z_req_valid = 1'b1; z_req_addr = 5'd7; z_req_len = 8'd2;
        tick();
        z_req_valid = 1'b0; z_req_addr = 5'd0; z_req_len = 8'd0;
        checkOutput("z7_en_c1", z_en, 1);
        checkOutput("z7_a_c1", z_a, 7);
        checkOutput("z7_done_c1", z_done, 0);
        tick();
        checkOutput("z7_en_c2", z_en, 1);
        checkOutput("z7_done_c2", z_done, 1);
        tick();
        checkOutput("z7_en_c3", z_en, 0);
        checkOutput("z7_busy_c3", z_busy, 0);
        checkOutput("z7_ready_c3", z_req_ready, 1);
        checkOutput("z7_done_c3", z_done, 0);

        $display("[TB] no-gap instance: scan dwell 1");
        z_scan_start = 1'b1; z_scan_dwell = 8'd1;
        tick();
        z_scan_start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            checkOutput($sformatf("zscan_en_c%0d", c), z_en, 1);
            checkOutput($sformatf("zscan_a_c%0d", c), z_a, c - 1);
            checkOutput($sformatf("zscan_done_c%0d", c), z_done, 1);
            checkOutput($sformatf("zscan_sdone_c%0d", c), z_scan_done, (c == 32));
            checkOutput($sformatf("zscan_busy_c%0d", c), z_busy, 1);
            tick();
        end
        checkOutput("zscan_end_busy", z_busy, 0);
        checkOutput("zscan_end_en", z_en, 0);
        checkOutput("zscan_end_a", z_a, 31);
        checkOutput("zscan_end_sdone", z_scan_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_sel_ctrl.md
# demux_sel_ctrl

Select sequencer that sits directly upstream of the 5-to-32 demux/decoder (`decoder5x32`) and drives its `a` and `en` inputs. It accepts single-select requests over a valid/ready handshake, holds the decoder enabled on the chosen line for a programmable dwell, then forces a break-before-make gap. It also provides an auto-scan mode that sweeps all 32 lines in order. Outputs are registered, so the decoder's active-low one-hot `y` is glitch-free and timing-predictable.

## Interface
- `GAP_CYCLES`, default 1: cycles with `en`=0 inserted after every selection; 0 allowed, meaning no gap.
- `CNT_W`, default 8: width of the dwell length fields.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: single-select request valid.
- `req_ready` out 1: block can accept a request.
- `req_addr` in 5: line to select, 0..31.
- `req_len` in CNT_W: dwell in cycles; 0 is treated as 1.
- `scan_start` in 1: one-cycle pulse; starts a 0..31 sweep.
- `scan_dwell` in CNT_W: dwell per line during a scan, sampled at scan start; 0 is treated as 1.
- `a` out 5: to decoder `a`, registered.
- `en` out 1: to decoder `en`, registered, active-high.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse at the end of each selection's dwell.
- `scan_done` out 1: one-cycle pulse at the end of the line-31 dwell in a scan.

## Operation
- Reset values: `a`=0, `en`=0, `busy`=0, `done`=0, `scan_done`=0, and state=IDLE. `req_ready` is 0 while `rst` is high.
- `req_ready` = (state==IDLE) && !`rst`. It is combinational from state and does not depend on `req_valid`.
- States:
  - IDLE to ACTIVE on request accept (`req_valid`&&`req_ready`). Latch `a`=`req_addr`, set the counter to max(`req_len`,1), clear the scan flag.
  - IDLE to ACTIVE on `scan_start` with no accept. Latch `a`=0, latch the dwell as max(`scan_dwell`,1), set the scan flag.
  - If accept and `scan_start` occur in the same cycle, the request wins and `scan_start` is dropped.
  - `scan_start` outside IDLE is ignored.
  - ACTIVE: `en`=1 and `a` is held. The counter decrements each cycle. On the last dwell cycle, pulse `done`, and go to GAP if `GAP_CYCLES`>0.
  - ACTIVE with `GAP_CYCLES`=0: go to IDLE, or in scan mode go to ACTIVE on the next line.
  - GAP: `en`=0 and `a` holds the last address. After `GAP_CYCLES` cycles, go to IDLE, or in scan mode go to ACTIVE with `a`+1.
  - Scan termination: after the line-31 dwell, pulse `scan_done` together with `done`. The block returns to IDLE after any gap; `a` never wraps to 0.
- `req_addr` and `req_len` are sampled only at accept. Changes afterwards have no effect.
- `en` is never high while `a` changes. Any address change happens in a cycle where `en` is 0 at that clock edge. With `GAP_CYCLES`=0 in scan mode, the step from line N to line N+1 is the only exception: `a` and `en` update in the same registered edge.
- `rst` asserted mid-operation returns all outputs to their reset values at the next edge. An in-flight request or scan is discarded.

## Timing
- Request accepted at edge k: `en`=1 with `a`=addr during cycles k+1..k+L, where L=max(`req_len`,1).
- `done` is high in cycle k+L.
- `en`=0 in cycles k+L+1..k+L+`GAP_CYCLES`.
- `req_ready` is high again in cycle k+L+`GAP_CYCLES`+1. Back-to-back request throughput is one per L+`GAP_CYCLES`+1 cycles.
- Scan started at edge k with dwell D: line n is enabled in cycles k+1+n·(D+`GAP_CYCLES`) .. k+n·(D+`GAP_CYCLES`)+D.
- Scan total time: IDLE is reached 32·(D+`GAP_CYCLES`) cycles after the start edge.
- `busy` rises in the cycle after accept or start. It falls in the same cycle `req_ready` rises.

## Test plan
- Reset with `req_valid`=1: while `rst`=1, require `req_ready`=0, `en`=0, `a`=0. The decoder output `y` must read 32'hFFFFFFFF.
- Single request, `req_addr`=5, `req_len`=3, `GAP_CYCLES`=1:
  - `en`=1 and `a`=5 for exactly 3 cycles, so `y`=32'hFFFFFFDF.
  - `done` pulses on the third cycle.
  - One gap cycle follows with `y`=32'hFFFFFFFF.
  - `req_ready` returns 5 cycles after the accept edge.
- `req_len`=0 with `req_addr`=31: exactly 1 cycle of `en`=1, giving `y`=32'h7FFFFFFF.
- Simultaneous `req_valid`(addr 2) and `scan_start` in IDLE: only address 2 is selected, and no scan follows.
- Scan with `scan_dwell`=2 and `GAP_CYCLES`=1:
  - Lines 0..31 are each enabled for 2 cycles, in order.
  - `en` never stays high across an address change.
  - `scan_done` pulses once, on the last line-31 cycle.
  - Total time is 96 cycles to IDLE.
- Assert `rst` during a scan at line 10: next cycle `en`=0, `a`=0, and `busy`=0. A subsequent request to address 1 behaves normally.
